// File: rtl/mod_counter_if.sv
// Control and status bundle for mod_counter: the master drives the count
// controls and the slave (the counter) returns count, terminal count and wrap.
interface mod_counter_if #(
  parameter int WIDTH = 32
);
  logic             i_ce;
  logic             i_clear;
  logic             i_load;
  logic [WIDTH-1:0] i_load_value;
  logic             i_up;
  logic [WIDTH-1:0] o_count;
  logic             o_tc;
  logic             o_wrap;

  modport master (
    output i_ce, i_clear, i_load, i_load_value, i_up,
    input  o_count, o_tc, o_wrap
  );

  modport slave (
    input  i_ce, i_clear, i_load, i_load_value, i_up,
    output o_count, o_tc, o_wrap
  );
endinterface

// File: rtl/mod_counter.sv
// Up/down modulo counter with load, clear, wrap/saturate and range-end pulse.
// Optional MOD_COUNTER_PRESCALER_EN inserts an i_ce prescaler before the count.
module mod_counter #(
  parameter int               WIDTH    = 32,
  parameter logic [WIDTH-1:0] INIT     = '0,
  parameter logic [WIDTH-1:0] MAX      = '1,
  parameter bit               SATURATE = 1'b0
`ifdef MOD_COUNTER_PRESCALER_EN
  ,
  parameter int               PRESCALE = 1
`endif
) (
  input  logic         i_clock,
  input  logic         i_reset,
  mod_counter_if.slave bus
);

  logic [WIDTH-1:0] count;
  logic [WIDTH-1:0] count_nxt;
  logic             wrap;
  logic             wrap_nxt;
  logic             step;

  function automatic logic [WIDTH-1:0] clamp_load(input logic [WIDTH-1:0] v);
    return (v > MAX) ? MAX : v;
  endfunction

  // Range ends are tested before any +1/-1 so the sum never needs a carry bit.
  function automatic logic [WIDTH-1:0] next_value(input logic [WIDTH-1:0] c,
                                                 input logic             up);
    if (up) begin
      if (c == MAX) return SATURATE ? MAX : '0;
      return c + 1'b1;
    end
    if (c == '0) return SATURATE ? '0 : MAX;
    return c - 1'b1;
  endfunction

  function automatic logic at_end(input logic [WIDTH-1:0] c, input logic up);
    return up ? (c == MAX) : (c == '0);
  endfunction

`ifdef MOD_COUNTER_PRESCALER_EN
  localparam int             PW       = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0]  PRE_LAST = PW'(PRESCALE - 1);

  logic [PW-1:0] pre;
  logic [PW-1:0] pre_nxt;

  assign step = (pre == PRE_LAST);

  always_comb begin
    pre_nxt = pre;
    if (bus.i_clear || bus.i_load) pre_nxt = '0;
    else if (bus.i_ce)             pre_nxt = step ? '0 : pre + 1'b1;
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) pre <= '0;
    else         pre <= pre_nxt;
  end
`else
  assign step = 1'b1;
`endif

  always_comb begin
    count_nxt = count;
    wrap_nxt  = 1'b0;
    if (bus.i_clear) begin
      count_nxt = INIT;
    end else if (bus.i_load) begin
      count_nxt = clamp_load(bus.i_load_value);
    end else if (bus.i_ce && step) begin
      count_nxt = next_value(count, bus.i_up);
      wrap_nxt  = at_end(count, bus.i_up);
    end
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      count <= INIT;
      wrap  <= 1'b0;
    end else begin
      count <= count_nxt;
      wrap  <= wrap_nxt;
    end
  end

  assign bus.o_count = count;
  assign bus.o_wrap  = wrap;
  assign bus.o_tc    = at_end(count, bus.i_up);

endmodule

// File: tb/tb_mod_counter.sv
// Directed bench for mod_counter: wrap and saturate instances (WIDTH=4, MAX=9),
// plus a PRESCALE=3 instance when MOD_COUNTER_PRESCALER_EN is defined.
module tb_mod_counter;
  logic clk = 1'b0;
  logic rst;
  int   total  = 0;
  int   passed = 0;

  always #5 clk = ~clk;

  mod_counter_if #(.WIDTH(4)) wa ();
  mod_counter_if #(.WIDTH(4)) sa ();

  mod_counter #(.WIDTH(4), .INIT(4'd0), .MAX(4'd9), .SATURATE(1'b0))
    dut_wrap (.i_clock(clk), .i_reset(rst), .bus(wa.slave));
  mod_counter #(.WIDTH(4), .INIT(4'd0), .MAX(4'd9), .SATURATE(1'b1))
    dut_sat (.i_clock(clk), .i_reset(rst), .bus(sa.slave));

`ifdef MOD_COUNTER_PRESCALER_EN
  mod_counter_if #(.WIDTH(4)) pa ();
  mod_counter #(.WIDTH(4), .INIT(4'd0), .MAX(4'd9), .SATURATE(1'b0), .PRESCALE(3))
    dut_pre (.i_clock(clk), .i_reset(rst), .bus(pa.slave));
`endif

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    {wa.i_ce, wa.i_clear, wa.i_load, wa.i_up} = 4'b0;
    {sa.i_ce, sa.i_clear, sa.i_load, sa.i_up} = 4'b0;
    wa.i_load_value = '0;
    sa.i_load_value = '0;
`ifdef MOD_COUNTER_PRESCALER_EN
    {pa.i_ce, pa.i_clear, pa.i_load, pa.i_up} = 4'b0;
    pa.i_load_value = '0;
`endif
    tick();
    tick();
    check("reset_count", wa.o_count, 0);
    check("reset_wrap", wa.o_wrap, 0);
    check("reset_sat_count", sa.o_count, 0);
    rst = 1'b0;

    // Wrap-mode up count: 1..9,0,1,2
    wa.i_ce = 1'b1;
    wa.i_up = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      tick();
      check($sformatf("up_count_%0d", k), wa.o_count, k % 10);
      check($sformatf("up_wrap_%0d", k), wa.o_wrap, (k % 10) == 0);
      check($sformatf("up_tc_%0d", k), wa.o_tc, (k % 10) == 9);
    end

    // Down count after load 2: 1,0,9,8
    wa.i_load = 1'b1;
    wa.i_load_value = 4'd2;
    tick();
    check("load2_count", wa.o_count, 2);
    wa.i_load = 1'b0;
    wa.i_up = 1'b0;
    begin
      int dexp[4] = '{1, 0, 9, 8};
      for (int k = 0; k < 4; k++) begin
        tick();
        check($sformatf("down_count_%0d", k), wa.o_count, dexp[k]);
        check($sformatf("down_wrap_%0d", k), wa.o_wrap, dexp[k] == 9);
        check($sformatf("down_tc_%0d", k), wa.o_tc, dexp[k] == 0);
      end
    end

    // Priority and load clamping
    wa.i_clear = 1'b1;
    wa.i_load = 1'b1;
    wa.i_load_value = 4'd5;
    wa.i_ce = 1'b1;
    tick();
    check("prio_clear_count", wa.o_count, 0);
    check("prio_clear_wrap", wa.o_wrap, 0);
    wa.i_clear = 1'b0;
    wa.i_load_value = 4'd15;
    tick();
    check("load_clamp_count", wa.o_count, 9);
    check("load_clamp_wrap", wa.o_wrap, 0);
    wa.i_load = 1'b0;
    wa.i_ce = 1'b0;
    wa.i_up = 1'b1;
    tick();
    check("hold_count", wa.o_count, 9);
    check("hold_wrap", wa.o_wrap, 0);
    check("hold_tc", wa.o_tc, 1);
    wa.i_up = 1'b0;
    #1;
    check("tc_dir_change", wa.o_tc, 0);
    wa.i_up = 1'b1;
    wa.i_ce = 1'b1;
    tick();
    check("max_wrap_count", wa.o_count, 0);
    check("max_wrap_pulse", wa.o_wrap, 1);

    // Asynchronous reset mid-cycle while at 6
    wa.i_load = 1'b1;
    wa.i_load_value = 4'd6;
    tick();
    check("load6_count", wa.o_count, 6);
    wa.i_load = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_count", wa.o_count, 0);
    for (int k = 0; k < 3; k++) begin
      tick();
      check($sformatf("rst_hold_%0d", k), wa.o_count, 0);
    end
    rst = 1'b0;
    tick();
    check("post_rst_count", wa.o_count, 1);
    wa.i_ce = 1'b0;

    // Saturate mode: from 7 -> 8,9,9,9,9
    sa.i_load = 1'b1;
    sa.i_load_value = 4'd7;
    sa.i_ce = 1'b1;
    sa.i_up = 1'b1;
    tick();
    check("sat_load7", sa.o_count, 7);
    sa.i_load = 1'b0;
    begin
      int sexp[5] = '{8, 9, 9, 9, 9};
      for (int k = 0; k < 5; k++) begin
        tick();
        check($sformatf("sat_up_count_%0d", k), sa.o_count, sexp[k]);
        check($sformatf("sat_up_wrap_%0d", k), sa.o_wrap, k >= 2);
      end
    end
    sa.i_ce = 1'b0;
    tick();
    check("sat_hold_wrap", sa.o_wrap, 0);
    sa.i_load = 1'b1;
    sa.i_load_value = 4'd0;
    tick();
    sa.i_load = 1'b0;
    sa.i_ce = 1'b1;
    sa.i_up = 1'b0;
    tick();
    check("sat_down_count", sa.o_count, 0);
    check("sat_down_wrap", sa.o_wrap, 1);
    sa.i_ce = 1'b0;

`ifdef MOD_COUNTER_PRESCALER_EN
    // Prescale by 3, then a load restarts the spacing
    pa.i_clear = 1'b1;
    tick();
    pa.i_clear = 1'b0;
    pa.i_ce = 1'b1;
    pa.i_up = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      tick();
      check($sformatf("pre_count_%0d", k), pa.o_count, k / 3);
    end
    tick();
    check("pre_partial", pa.o_count, 3);
    pa.i_load = 1'b1;
    pa.i_load_value = 4'd5;
    tick();
    check("pre_load5", pa.o_count, 5);
    pa.i_load = 1'b0;
    begin
      int pexp[3] = '{5, 5, 6};
      for (int k = 0; k < 3; k++) begin
        tick();
        check($sformatf("pre_after_load_%0d", k), pa.o_count, pexp[k]);
        check($sformatf("pre_after_load_wrap_%0d", k), pa.o_wrap, 0);
      end
    end
    pa.i_ce = 1'b0;
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
